// File: rtl/ov7670_pkg.sv
// Shared types and constants for the OV7670 capture controller.
// State codes double as the db_estado debug output.
package ov7670_pkg;

    typedef enum logic [3:0] {
        INICIAL      = 4'd0,
        ARMA         = 4'd1,
        ESPERA_FRAME = 4'd2,
        ESPERA_LINHA = 4'd3,
        BYTE_ALTO    = 4'd4,
        BYTE_BAIXO   = 4'd5,
        ESCREVE      = 4'd6,
        FIM          = 4'd7
    } state_t;

    localparam int RGB_R_W         = 5;
    localparam int RGB_G_W         = 6;
    localparam int RGB_B_W         = 5;
    localparam int BYTE_W          = 8;
    localparam int BYTES_PER_PIXEL = 2;
    localparam int PIXEL_W         = BYTE_W * BYTES_PER_PIXEL;

endpackage

// File: rtl/ov7670_capture_ctrl_packer.sv
// Byte latch and RGB565 pair assembly; a lone high byte is simply
// never paired, which discards a half pixel at line end.
module ov7670_pixel_packer
    import ov7670_pkg::*;
(
    input  logic               clock,
    input  logic               reset,
    input  logic [BYTE_W-1:0]  D,
    input  logic               pclk_rise,
    input  logic               HREF,
    input  logic               accept,
    input  logic               low_byte,
    output logic [PIXEL_W-1:0] pixel,
    output logic               valid
);

    logic [BYTE_W-1:0] high;
    logic              take;

    assign take  = accept & pclk_rise & HREF;
    assign valid = take & low_byte;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            high  <= '0;
            pixel <= '0;
        end else if (take && !low_byte) begin
            high <= D;
        end else if (valid) begin
            pixel <= {high, D};
        end
    end

endmodule

// File: rtl/ov7670_capture_ctrl.sv
// OV7670 frame capture FSM with row/column/address counters.
// Define OV7670_DECIM2_EN to store only even rows and even columns.
module ov7670_capture_ctrl
    import ov7670_pkg::*;
#(
    parameter int IMG_W  = 640,
    parameter int IMG_H  = 480,
    parameter int COL_W  = 10,
    parameter int ROW_W  = 9,
    parameter int ADDR_W = 19
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              iniciar,
    input  logic              continuo,
    input  logic              VSYNC,
    input  logic              HREF,
    input  logic              pclk_rise,
    input  logic [7:0]        D,
    output logic              PWDN,
    output logic              write_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [15:0]       wr_data,
    output logic [ROW_W-1:0]  linha,
    output logic [COL_W-1:0]  coluna,
    output logic              frame_done,
    output logic              frame_err,
    output logic              ocupado,
    output logic [3:0]        db_estado
);

    localparam logic [ROW_W-1:0] H_LIM = ROW_W'(IMG_H);
    localparam logic [COL_W-1:0] W_LIM = COL_W'(IMG_W);

    state_t            state, next;
    logic [ROW_W-1:0]  linha_n;
    logic [COL_W-1:0]  coluna_n;
    logic [ADDR_W-1:0] addr, addr_n;
    logic              ok, ok_n;
    logic              pix_valid;
    logic              in_win;

    ov7670_pixel_packer u_packer (
        .clock     (clock),
        .reset     (reset),
        .D         (D),
        .pclk_rise (pclk_rise),
        .HREF      (HREF),
        .accept    (state == BYTE_ALTO || state == BYTE_BAIXO),
        .low_byte  (state == BYTE_BAIXO),
        .pixel     (wr_data),
        .valid     (pix_valid)
    );

`ifdef OV7670_DECIM2_EN
    assign in_win = (linha < H_LIM) && (coluna < W_LIM)
                    && !linha[0] && !coluna[0];
`else
    assign in_win = (linha < H_LIM) && (coluna < W_LIM);
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state  <= INICIAL;
            linha  <= '0;
            coluna <= '0;
            addr   <= '0;
            ok     <= 1'b0;
        end else begin
            state  <= next;
            linha  <= linha_n;
            coluna <= coluna_n;
            addr   <= addr_n;
            ok     <= ok_n;
        end
    end

    always_comb begin
        next     = state;
        linha_n  = linha;
        coluna_n = coluna;
        addr_n   = addr;
        ok_n     = ok;
        write_en = 1'b0;
        unique case (state)
            INICIAL: if (iniciar) next = ARMA;
            ARMA: if (VSYNC) next = ESPERA_FRAME;
            ESPERA_FRAME: begin
                if (!VSYNC) begin
                    linha_n  = '0;
                    coluna_n = '0;
                    addr_n   = '0;
                    next     = ESPERA_LINHA;
                end
            end
            ESPERA_LINHA: begin
                if (VSYNC) begin
                    ok_n = (linha >= H_LIM);
                    next = FIM;
                end else if (HREF) begin
                    next = BYTE_ALTO;
                end
            end
            BYTE_ALTO, BYTE_BAIXO: begin
                if (VSYNC) begin
                    ok_n = 1'b0;
                    next = FIM;
                end else if (!HREF) begin
                    coluna_n = '0;
                    if (linha != '1) linha_n = linha + ROW_W'(1);
                    next = ESPERA_LINHA;
                end else if (state == BYTE_ALTO && pclk_rise) begin
                    next = BYTE_BAIXO;
                end else if (state == BYTE_BAIXO && pix_valid) begin
                    next = ESCREVE;
                end
            end
            ESCREVE: begin
                // The pending pixel is stored even if VSYNC cuts the frame
                write_en = in_win;
                if (in_win) addr_n = addr + ADDR_W'(1);
                if (coluna != '1) coluna_n = coluna + COL_W'(1);
                if (VSYNC) begin
                    ok_n = 1'b0;
                    next = FIM;
                end else begin
                    next = BYTE_ALTO;
                end
            end
            FIM: next = continuo ? ARMA : INICIAL;
            default: next = INICIAL;
        endcase
    end

    assign wr_addr    = addr;
    assign frame_done = (state == FIM) && ok;
    assign frame_err  = (state == FIM) && !ok;
    assign ocupado    = (state != INICIAL);
    assign PWDN       = (state == INICIAL);
    assign db_estado  = state;

endmodule
